// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat game: card ranks, card value and
// the state encoding used by the game statemachine.
package baccarat_pkg;

    typedef logic [3:0] rank_t;

    localparam rank_t RANK_EMPTY = 4'd0;
    localparam rank_t RANK_ACE   = 4'd1;
    localparam rank_t RANK_KING  = 4'd13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEAL_P1,
        ST_DEAL_D1,
        ST_DEAL_P2,
        ST_DEAL_D2,
        ST_DEAL_P3,
        ST_DEAL_D3,
        ST_RESULT
    } state_t;

    // Baccarat value: pips count at face value, tens and court cards count zero.
    function automatic logic [3:0] card_value(input rank_t r);
        return (r >= RANK_ACE && r <= 4'd9) ? r : 4'd0;
    endfunction

endpackage

// File: rtl/card_shoe.sv
// Card source: free-running rank counter plus, when SHOE_TRACK_EN is defined,
// a finite shoe with per-rank counts, wrap-around search and reshuffle.
module card_shoe
    import baccarat_pkg::*;
#(
    parameter int NUM_DECKS    = 1,
    parameter int RESHUFFLE_AT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_hand,
    input  logic       draw,
    output rank_t      rank,
    output logic [7:0] cards_left,
    output logic       empty
);

    localparam logic [7:0] FULL_SHOE = 8'(52 * NUM_DECKS);
    localparam logic [7:0] PER_RANK  = 8'(4 * NUM_DECKS);

    rank_t ctr;

    always_ff @(posedge clk) begin
        if (reset)
            ctr <= RANK_ACE;
        else
            ctr <= (ctr == RANK_KING) ? RANK_ACE : ctr + 4'd1;
    end

`ifdef SHOE_TRACK_EN
    logic [7:0] count [13];
    logic [3:0] base;
    logic [4:0] sum;
    logic [3:0] pick_idx;
    logic       found;

    // First rank with cards remaining, searching upward from the counter.
    always_comb begin
        base     = ctr - 4'd1;
        sum      = 5'd0;
        pick_idx = 4'd0;
        found    = 1'b0;
        for (int i = 0; i < 13; i++) begin
            sum = {1'b0, base} + 5'(i);
            if (sum >= 5'd13) sum = sum - 5'd13;
            if (sum >= 5'd13) sum = sum - 5'd13;
            if (!found && count[sum[3:0]] != 8'd0) begin
                found    = 1'b1;
                pick_idx = sum[3:0];
            end
        end
    end

    assign rank  = found ? rank_t'(pick_idx + 4'd1) : RANK_EMPTY;
    assign empty = (cards_left == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 13; i++) count[i] <= PER_RANK;
            cards_left <= FULL_SHOE;
        end else if (new_hand) begin
            if (cards_left < 8'(RESHUFFLE_AT)) begin
                for (int i = 0; i < 13; i++) count[i] <= PER_RANK;
                cards_left <= FULL_SHOE;
            end
        end else if (draw && !empty) begin
            count[pick_idx] <= count[pick_idx] - 8'd1;
            cards_left      <= cards_left - 8'd1;
        end
    end
`else
    logic unused_shoe_inputs;

    assign unused_shoe_inputs = draw ^ new_hand;
    assign rank       = ctr;
    assign cards_left = FULL_SHOE;
    assign empty      = 1'b0;
`endif

endmodule

// File: rtl/card_dealer.sv
// Card slots, hand scores and strobe error flag for the baccarat datapath.
// Define SHOE_TRACK_EN for a finite shoe; otherwise the deck is infinite.
module card_dealer
    import baccarat_pkg::*;
#(
    parameter int NUM_DECKS    = 1,
    parameter int RESHUFFLE_AT = 6
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       new_hand,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3_val,
    output logic [7:0] cards_left,
    output logic       strobe_err
);

    // Handshake: load_* strobes have no ready; exactly one high strobe is
    // accepted at the edge it is sampled, and the result is visible after it.
    logic [5:0] loads;
    logic       multi;
    logic       single;
    logic       draw;
    logic       empty;
    rank_t      rank;
    rank_t      slot [6];
    logic [4:0] psum;
    logic [4:0] dsum;

    assign loads  = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};
    assign multi  = |(loads & (loads - 6'd1));
    assign single = (|loads) && !multi;
    assign draw   = single && !new_hand;

    card_shoe #(
        .NUM_DECKS   (NUM_DECKS),
        .RESHUFFLE_AT(RESHUFFLE_AT)
    ) u_shoe (
        .clk       (slow_clock),
        .reset     (reset),
        .new_hand  (new_hand),
        .draw      (draw),
        .rank      (rank),
        .cards_left(cards_left),
        .empty     (empty)
    );

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) slot[i] <= RANK_EMPTY;
            strobe_err <= 1'b0;
        end else if (new_hand) begin
            for (int i = 0; i < 6; i++) slot[i] <= RANK_EMPTY;
        end else if (multi) begin
            strobe_err <= 1'b1;
        end else if (single) begin
            for (int i = 0; i < 6; i++)
                if (loads[i]) slot[i] <= empty ? RANK_EMPTY : rank;
            if (empty) strobe_err <= 1'b1;
        end
    end

    assign pcard1 = slot[0];
    assign pcard2 = slot[1];
    assign pcard3 = slot[2];
    assign dcard1 = slot[3];
    assign dcard2 = slot[4];
    assign dcard3 = slot[5];

    // Sum of three values is at most 27, so two conditional subtracts give mod 10.
    assign psum = 5'(card_value(slot[0])) + 5'(card_value(slot[1])) + 5'(card_value(slot[2]));
    assign dsum = 5'(card_value(slot[3])) + 5'(card_value(slot[4])) + 5'(card_value(slot[5]));

    assign pscore = (psum >= 5'd20) ? 4'(psum - 5'd20) :
                    (psum >= 5'd10) ? 4'(psum - 5'd10) : psum[3:0];
    assign dscore = (dsum >= 5'd20) ? 4'(dsum - 5'd20) :
                    (dsum >= 5'd10) ? 4'(dsum - 5'd10) : dsum[3:0];

    assign pcard3_val = card_value(slot[2]);

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer; shoe tests run when
// SHOE_TRACK_EN is defined, infinite-deck tests otherwise.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_hand = 1'b0;
    logic [5:0] ld = 6'd0;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore, pcard3_val;
    logic [7:0] cards_left;
    logic       strobe_err;

    logic [3:0] ctr = 4'd1;
    int         n_checks = 0;
    int         n_fail = 0;

`ifdef SHOE_TRACK_EN
    localparam int DC = 1;
`else
    localparam int DC = 0;
`endif

    card_dealer #(.NUM_DECKS(1), .RESHUFFLE_AT(6)) dut (
        .slow_clock (clk),
        .reset      (reset),
        .new_hand   (new_hand),
        .load_pcard1(ld[0]),
        .load_pcard2(ld[1]),
        .load_pcard3(ld[2]),
        .load_dcard1(ld[3]),
        .load_dcard2(ld[4]),
        .load_dcard3(ld[5]),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .pcard3_val (pcard3_val),
        .cards_left (cards_left),
        .strobe_err (strobe_err)
    );

    always #5 clk = ~clk;

    // Reference rank counter: 1 after reset, then 2..13, 1, ...
    always @(posedge clk) begin
        if (reset) ctr <= 4'd1;
        else       ctr <= (ctr == 4'd13) ? 4'd1 : ctr + 4'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [5:0] m);
        ld = m;
        tick();
        ld = 6'd0;
    endtask

    task automatic hand_over();
        new_hand = 1'b1;
        tick();
        new_hand = 1'b0;
    endtask

    task automatic wait_ctr(input logic [3:0] v);
        for (int i = 0; i < 20 && ctr != v; i++) tick();
        if (ctr != v) begin
            n_checks++; n_fail++;
            $display("FAIL wait_ctr: counter %0d, required %0d", ctr, v);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0) begin
            n_fail++; $display("FAIL reset_slots: got %h want 000000",
                {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3});
        end
        n_checks++;
        if ({pscore, dscore, pcard3_val} !== 12'h0) begin
            n_fail++; $display("FAIL reset_scores: got %h want 000", {pscore, dscore, pcard3_val});
        end
        n_checks++;
        if (cards_left !== 8'd52) begin
            n_fail++; $display("FAIL reset_cards_left: got %0d want 52", cards_left);
        end
        n_checks++;
        if (strobe_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", strobe_err);
        end
        pulse(6'b000001);
        n_checks++;
        if (pcard1 !== 4'd1 || pscore !== 4'd1) begin
            n_fail++; $display("FAIL first_draw: pcard1 %0d pscore %0d want 1 1", pcard1, pscore);
        end
    endtask

    task automatic test_draw();
        do_reset();
        wait_ctr(4'd7);
        pulse(6'b000001);
        n_checks++;
        if (pcard1 !== 4'd7 || pscore !== 4'd7) begin
            n_fail++; $display("FAIL draw_p1: pcard1 %0d pscore %0d want 7 7", pcard1, pscore);
        end
        wait_ctr(4'd12);
        pulse(6'b000010);
        n_checks++;
        if (pcard2 !== 4'd12 || pscore !== 4'd7) begin
            n_fail++; $display("FAIL draw_p2: pcard2 %0d pscore %0d want 12 7", pcard2, pscore);
        end
        n_checks++;
        if (cards_left !== 8'(52 - 2 * DC)) begin
            n_fail++; $display("FAIL draw_left: got %0d want %0d", cards_left, 52 - 2 * DC);
        end
    endtask

    task automatic test_third_card();
        do_reset();
        wait_ctr(4'd9);  pulse(6'b000001);
        wait_ctr(4'd8);  pulse(6'b000010);
        n_checks++;
        if (pscore !== 4'd7) begin
            n_fail++; $display("FAIL two_card_score: got %0d want 7", pscore);
        end
        wait_ctr(4'd5);  pulse(6'b000100);
        n_checks++;
        if (pscore !== 4'd2 || pcard3_val !== 4'd5) begin
            n_fail++; $display("FAIL third_card: pscore %0d pcard3_val %0d want 2 5", pscore, pcard3_val);
        end
        wait_ctr(4'd13); pulse(6'b001000);
        wait_ctr(4'd6);  pulse(6'b010000);
        n_checks++;
        if (dscore !== 4'd6 || dcard1 !== 4'd13) begin
            n_fail++; $display("FAIL dealer_score: dscore %0d dcard1 %0d want 6 13", dscore, dcard1);
        end
        wait_ctr(4'd3);  pulse(6'b010000);
        n_checks++;
        if (dcard2 !== 4'd3 || dscore !== 4'd3) begin
            n_fail++; $display("FAIL overwrite: dcard2 %0d dscore %0d want 3 3", dcard2, dscore);
        end
        wait_ctr(4'd11); pulse(6'b000100);
        n_checks++;
        if (pcard3_val !== 4'd0 || pscore !== 4'd7) begin
            n_fail++; $display("FAIL court_third: pcard3_val %0d pscore %0d want 0 7", pcard3_val, pscore);
        end
        n_checks++;
        if (cards_left !== 8'(52 - 7 * DC)) begin
            n_fail++; $display("FAIL third_left: got %0d want %0d", cards_left, 52 - 7 * DC);
        end
    endtask

    task automatic test_multi_strobe();
        pulse(6'b001001);
        n_checks++;
        if (pcard1 !== 4'd9 || dcard1 !== 4'd13) begin
            n_fail++; $display("FAIL multi_slots: pcard1 %0d dcard1 %0d want 9 13", pcard1, dcard1);
        end
        n_checks++;
        if (cards_left !== 8'(52 - 7 * DC) || strobe_err !== 1'b1) begin
            n_fail++; $display("FAIL multi_flag: left %0d err %b want %0d 1", cards_left, strobe_err, 52 - 7 * DC);
        end
        wait_ctr(4'd2);  pulse(6'b000010);
        n_checks++;
        if (pcard2 !== 4'd2 || strobe_err !== 1'b1) begin
            n_fail++; $display("FAIL sticky_err: pcard2 %0d err %b want 2 1", pcard2, strobe_err);
        end
        new_hand = 1'b1; ld = 6'b000001;
        tick();
        new_hand = 1'b0; ld = 6'd0;
        n_checks++;
        if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0 || cards_left !== 8'(52 - 8 * DC)) begin
            n_fail++; $display("FAIL new_hand_wins: slots %h left %0d want 000000 %0d",
                {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, cards_left, 52 - 8 * DC);
        end
        n_checks++;
        if (strobe_err !== 1'b1) begin
            n_fail++; $display("FAIL err_after_new_hand: got %b want 1", strobe_err);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        pulse(6'b000001);
        pulse(6'b001000);
        pulse(6'b000011);
        do_reset();
        n_checks++;
        if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0 || {pscore, dscore} !== 8'h0) begin
            n_fail++; $display("FAIL mid_reset_slots: slots %h scores %h want 0",
                {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, {pscore, dscore});
        end
        n_checks++;
        if (cards_left !== 8'd52 || strobe_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_shoe: left %0d err %b want 52 0", cards_left, strobe_err);
        end
    endtask

`ifdef SHOE_TRACK_EN
    task automatic test_exhaust();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_ctr(4'd4); pulse(6'b000001);
        end
        wait_ctr(4'd4); pulse(6'b000001);
        n_checks++;
        if (pcard1 !== 4'd5) begin
            n_fail++; $display("FAIL exhausted_skip: got %0d want 5", pcard1);
        end
        for (int i = 0; i < 3; i++) begin
            wait_ctr(4'd5); pulse(6'b000010);
        end
        wait_ctr(4'd4); pulse(6'b000001);
        n_checks++;
        if (pcard2 !== 4'd5 || pcard1 !== 4'd6) begin
            n_fail++; $display("FAIL count5_consumed: pcard2 %0d pcard1 %0d want 5 6", pcard2, pcard1);
        end
        for (int i = 0; i < 4; i++) begin
            wait_ctr(4'd13); pulse(6'b001000);
        end
        wait_ctr(4'd13); pulse(6'b001000);
        n_checks++;
        if (dcard1 !== 4'd1 || cards_left !== 8'd38) begin
            n_fail++; $display("FAIL search_wrap: dcard1 %0d left %0d want 1 38", dcard1, cards_left);
        end
    endtask

    task automatic test_reshuffle();
        do_reset();
        for (int i = 0; i < 46; i++) pulse(6'b000001);
        hand_over();
        n_checks++;
        if (cards_left !== 8'd6 || pcard1 !== 4'd0) begin
            n_fail++; $display("FAIL no_reshuffle_at_6: left %0d pcard1 %0d want 6 0", cards_left, pcard1);
        end
        pulse(6'b000001);
        hand_over();
        n_checks++;
        if (cards_left !== 8'd52 || pcard1 !== 4'd0) begin
            n_fail++; $display("FAIL reshuffle_at_5: left %0d pcard1 %0d want 52 0", cards_left, pcard1);
        end
        for (int i = 0; i < 52; i++) pulse(6'b000001);
        n_checks++;
        if (cards_left !== 8'd0 || strobe_err !== 1'b0) begin
            n_fail++; $display("FAIL shoe_drained: left %0d err %b want 0 0", cards_left, strobe_err);
        end
        pulse(6'b000001);
        n_checks++;
        if (pcard1 !== 4'd0 || strobe_err !== 1'b1 || cards_left !== 8'd0) begin
            n_fail++; $display("FAIL empty_draw: pcard1 %0d err %b left %0d want 0 1 0",
                pcard1, strobe_err, cards_left);
        end
    endtask
`else
    task automatic test_infinite();
        do_reset();
        for (int i = 0; i < 60; i++) pulse(6'b000001);
        n_checks++;
        if (cards_left !== 8'd52 || strobe_err !== 1'b0) begin
            n_fail++; $display("FAIL infinite_deck: left %0d err %b want 52 0", cards_left, strobe_err);
        end
        wait_ctr(4'd3); pulse(6'b000100);
        n_checks++;
        if (pcard3 !== 4'd3 || pcard3_val !== 4'd3) begin
            n_fail++; $display("FAIL infinite_draw: pcard3 %0d val %0d want 3 3", pcard3, pcard3_val);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_draw();
        test_third_card();
        test_multi_strobe();
        test_mid_reset();
`ifdef SHOE_TRACK_EN
        test_exhaust();
        test_reshuffle();
`else
        test_infinite();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
